morse_decoder: RTL
==================

MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 Parameter UNIT_CYCLES, default 5000000, Morse unit length in clk cycles (50 ms at 100 MHz); legal range >= 2.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, cycles the synchronized key must be stable before the debounced key changes; legal range >= 1.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 key  input  1  raw asynchronous Morse key; 1 = pressed.
REQ-006 code  output  6  last decoded character: 0-9 = digits '0'-'9', 10-35 = letters 'A'-'Z'; this is the 6-bit character code consumed by the downstream seven-segment stage.
REQ-007 code_valid  output  1  one-cycle pulse, code updated this cycle.
REQ-008 code_err  output  1  one-cycle pulse, unrecognised or over-long sequence.
REQ-009 busy  output  1  high in any state other than IDLE.

Function
REQ-010 key SHALL pass through a 2-flop synchronizer; key_db SHALL change only after key_sync holds the new value for DEBOUNCE_CYCLES consecutive cycles.
REQ-011 Symbol buffer: len (3 bits, 0-5) and pat (5 bits); each new symbol shifts pat left and enters at bit 0 (1 = dash, 0 = dot), so the first symbol sits at bit len-1.
REQ-012 Overflow flag SHALL set when a symbol arrives with len already 5; len and pat then hold.
REQ-013 Timing counter SHALL saturate at 3*UNIT_CYCLES and SHALL clear on every state transition.
REQ-014 FSM states: IDLE, PRESS, GAP, EMIT.
REQ-015 IDLE: on key_db rising edge -> PRESS.
REQ-016 PRESS: counter counts; on key_db falling edge, count < 2*UNIT_CYCLES appends a dot, otherwise appends a dash; -> GAP.
REQ-017 GAP: key_db rising edge while count < 3*UNIT_CYCLES -> PRESS (same character).
REQ-018 GAP: if count reaches 3*UNIT_CYCLES with key_db low -> EMIT.
REQ-019 GAP: a rise and timeout in the same cycle SHALL give priority to EMIT; the press is taken from IDLE on the following cycle if key_db is still high.
REQ-020 EMIT lasts one cycle: if the overflow flag is clear and (len,pat) matches the international Morse table for A-Z or 0-9, code <= mapped value and code_valid = 1; otherwise code_err = 1 and code holds. The buffer and overflow flag are cleared. -> IDLE.
REQ-021 code_valid and code_err SHALL never assert together and SHALL never assert outside the EMIT cycle.
REQ-022 Latency: the EMIT pulse SHALL occur exactly 3*UNIT_CYCLES+1 cycles after the debounced release of the final symbol.
REQ-023 code SHALL hold its value between emits; the encoding 36-63 is never produced.
REQ-024 Table anchors: ".-" -> 10 (A), "." -> 14 (E), "---" -> 24 (O), "..." -> 28 (S), "-" -> 29 (T), "-----" -> 0, "....." -> 5.
REQ-025 The implementation SHALL be a synthesizable single-clock design with no latches and no combinational path from key to any output.

Reset
REQ-026 While rst = 1, at the next clk edge: state = IDLE, synchronizer = 0, key_db = 0, counters = 0, len = 0, pat = 0, overflow = 0, code = 0, code_valid = 0, code_err = 0, busy = 0.
REQ-027 rst asserted mid-PRESS or mid-GAP SHALL discard the partial character with no pulse emitted.
REQ-028 If key is high when rst deasserts, the block SHALL treat it as a new press once debounced.

Verification (UNIT_CYCLES = 4, DEBOUNCE_CYCLES = 2)
REQ-029 Press 2 cycles, release 3, press 10, release >= 13 -> code = 10, code_valid one cycle, code_err = 0, busy returns to 0.
REQ-030 Five presses of 10 cycles each, 3-cycle gaps between them -> code = 0.
REQ-031 Six dots -> code_err pulse; code keeps its previous value.
REQ-032 "..--.." (invalid but <= 5? no, 6 symbols) then "-.-.-" (5 symbols, unmapped) -> code_err each time; no code_valid.
REQ-033 Key glitch of 1 cycle high -> no state change, busy stays 0.
REQ-034 rst pulse during GAP after "..." -> no pulse; the following "-" alone decodes to 29.

Source files
------------

// File: rtl/morse_decoder.sv
// Morse key decoder: synchronizes and debounces a raw key, times presses and
// gaps in units of UNIT_CYCLES, and emits a 6-bit character code per letter/digit.
module morse_decoder #(
    parameter int unsigned UNIT_CYCLES     = 5000000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    output logic [5:0] code,
    output logic       code_valid,
    output logic       code_err,
    output logic       busy
);

    localparam int unsigned GAP_LIMIT = 3 * UNIT_CYCLES;
    localparam int unsigned DASH_MIN  = 2 * UNIT_CYCLES;
    localparam int unsigned TW        = $clog2(GAP_LIMIT + 1);
    localparam int unsigned DW        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        GAP,
        EMIT
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic            key_db_q, key_db_d;
    logic [DW-1:0]   db_cnt_q, db_cnt_d;
    logic [TW-1:0]   tim_q, tim_d;
    logic [2:0]      len_q, len_d;
    logic [4:0]      pat_q, pat_d;
    logic            ovf_q, ovf_d;
    logic [5:0]      code_q, code_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            dash;
    logic [6:0]      lut;

    function automatic logic [6:0] morse_lookup(input logic [2:0] len, input logic [4:0] pat);
        logic [6:0] r;
        r = '0;
        case ({len, pat})
            {3'd2, 5'b00001}: r = {1'b1, 6'd10};
            {3'd4, 5'b01000}: r = {1'b1, 6'd11};
            {3'd4, 5'b01010}: r = {1'b1, 6'd12};
            {3'd3, 5'b00100}: r = {1'b1, 6'd13};
            {3'd1, 5'b00000}: r = {1'b1, 6'd14};
            {3'd4, 5'b00010}: r = {1'b1, 6'd15};
            {3'd3, 5'b00110}: r = {1'b1, 6'd16};
            {3'd4, 5'b00000}: r = {1'b1, 6'd17};
            {3'd2, 5'b00000}: r = {1'b1, 6'd18};
            {3'd4, 5'b00111}: r = {1'b1, 6'd19};
            {3'd3, 5'b00101}: r = {1'b1, 6'd20};
            {3'd4, 5'b00100}: r = {1'b1, 6'd21};
            {3'd2, 5'b00011}: r = {1'b1, 6'd22};
            {3'd2, 5'b00010}: r = {1'b1, 6'd23};
            {3'd3, 5'b00111}: r = {1'b1, 6'd24};
            {3'd4, 5'b00110}: r = {1'b1, 6'd25};
            {3'd4, 5'b01101}: r = {1'b1, 6'd26};
            {3'd3, 5'b00010}: r = {1'b1, 6'd27};
            {3'd3, 5'b00000}: r = {1'b1, 6'd28};
            {3'd1, 5'b00001}: r = {1'b1, 6'd29};
            {3'd3, 5'b00001}: r = {1'b1, 6'd30};
            {3'd4, 5'b00001}: r = {1'b1, 6'd31};
            {3'd3, 5'b00011}: r = {1'b1, 6'd32};
            {3'd4, 5'b01001}: r = {1'b1, 6'd33};
            {3'd4, 5'b01011}: r = {1'b1, 6'd34};
            {3'd4, 5'b01100}: r = {1'b1, 6'd35};
            {3'd5, 5'b11111}: r = {1'b1, 6'd0};
            {3'd5, 5'b01111}: r = {1'b1, 6'd1};
            {3'd5, 5'b00111}: r = {1'b1, 6'd2};
            {3'd5, 5'b00011}: r = {1'b1, 6'd3};
            {3'd5, 5'b00001}: r = {1'b1, 6'd4};
            {3'd5, 5'b00000}: r = {1'b1, 6'd5};
            {3'd5, 5'b10000}: r = {1'b1, 6'd6};
            {3'd5, 5'b11000}: r = {1'b1, 6'd7};
            {3'd5, 5'b11100}: r = {1'b1, 6'd8};
            {3'd5, 5'b11110}: r = {1'b1, 6'd9};
            default:          r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        db_cnt_d = db_cnt_q;
        key_db_d = key_db_q;
        if (sync2_q == key_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            key_db_d = sync2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // The FSM reacts to the debouncer's next value so it moves on the same
    // edge the debounced key changes; this fixes the emit latency at 3U+1.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (key_db_d) state_d = PRESS;
            PRESS:   if (!key_db_d) state_d = GAP;
            GAP: begin
                if (tim_q == TW'(GAP_LIMIT)) state_d = EMIT;
                else if (key_db_d)           state_d = PRESS;
            end
            EMIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign dash = (tim_q >= TW'(DASH_MIN));
    assign lut  = morse_lookup(len_q, pat_q);

    always_comb begin
        tim_d   = tim_q;
        len_d   = len_q;
        pat_d   = pat_q;
        ovf_d   = ovf_q;
        code_d  = code_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        if (state_d != state_q || state_q == IDLE) begin
            tim_d = '0;
        end else if (tim_q != TW'(GAP_LIMIT)) begin
            tim_d = tim_q + 1'b1;
        end

        if (state_q == PRESS && state_d == GAP) begin
            if (len_q == 3'd5) begin
                ovf_d = 1'b1;
            end else begin
                pat_d = {pat_q[3:0], dash};
                len_d = len_q + 3'd1;
            end
        end else if (state_q == EMIT) begin
            len_d = '0;
            pat_d = '0;
            ovf_d = 1'b0;
        end

        // Pulses are registered on entry so they line up with the EMIT cycle.
        if (state_q == GAP && state_d == EMIT) begin
            if (!ovf_q && lut[6]) begin
                code_d  = lut[5:0];
                valid_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            key_db_q <= 1'b0;
            db_cnt_q <= '0;
            tim_q    <= '0;
            len_q    <= '0;
            pat_q    <= '0;
            ovf_q    <= 1'b0;
            code_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= key;
            sync2_q  <= sync1_q;
            key_db_q <= key_db_d;
            db_cnt_q <= db_cnt_d;
            tim_q    <= tim_d;
            len_q    <= len_d;
            pat_q    <= pat_d;
            ovf_q    <= ovf_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign code       = code_q;
    assign code_valid = valid_q;
    assign code_err   = err_q;
    assign busy       = (state_q != IDLE);

endmodule
